md5_step_sequencer: RTL and testbench

//   Control FSM for the MD5 compression datapath. One start request runs all 64 steps.
//   Per step it drives: step_index (straight into the rotate unit), round-function select,

---
 rtl/md5_step_sequencer.sv | 83 ++++++++
 tb/tb_md5_step_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/md5_step_sequencer.sv
// md5_step_sequencer: control FSM that sequences the 64 MD5 steps of one block.
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   start       request a 64-step run (sampled only in IDLE)
//   hold        stall step progress while in RUN
//   busy        high in INIT, RUN, FINAL and DONE
//   load_init   one-cycle strobe to load A..D from the chaining value
//   step_en     strobe on the last datapath cycle of each step
//   step_index  current step 0..63
//   func_sel    round function select (step_index[5:4])
//   word_index  message word index g for the current step
//   final_add   one-cycle strobe to add A..D into the chaining value
//   done        one-cycle pulse, digest for this block valid
module md5_step_sequencer #(
    parameter int CYCLES_PER_STEP = 1,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hold,
    output logic       busy,
    output logic       load_init,
    output logic       step_en,
    output logic [5:0] step_index,
    output logic [1:0] func_sel,
    output logic [3:0] word_index,
    output logic       final_add,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, INIT, RUN, FINAL, DONE} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_STEP - 1);
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [3:0] i;
    logic last;
    assign last = cnt == LAST;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            step_index <= '0;
        end else begin
            case (state)
                IDLE: if (start) state <= INIT;
                INIT: begin
                    cnt <= '0;
                    step_index <= '0;
                    state <= RUN;
                end
                RUN: if (!hold) begin
                    if (last) begin
                        cnt <= '0;
                        // step_index holds at 63 through FINAL/DONE instead of wrapping
                        if (step_index == 6'd63) state <= FINAL;
                        else step_index <= step_index + 6'd1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FINAL: state <= DONE;
                DONE: begin
                    step_index <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign busy = state != IDLE;
    assign load_init = state == INIT;
    assign step_en = state == RUN && last && !hold;
    assign final_add = state == FINAL;
    assign done = state == DONE;
    assign func_sel = step_index[5:4];
    assign i = step_index[3:0];
    always_comb begin
        word_index = func_sel == 2'd0 ? i :
                     func_sel == 2'd1 ? i * 4'd5 + 4'd1 :
                     func_sel == 2'd2 ? i * 4'd3 + 4'd5 :
                                        i * 4'd7;
    end
endmodule

// File: tb/tb_md5_step_sequencer.sv
// tb_md5_step_sequencer: directed, table-driven checks of the MD5 step sequencer.
module tb_md5_step_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, hold;
    logic busy, load_init, step_en, final_add, done;
    logic [5:0] step_index;
    logic [1:0] func_sel;
    logic [3:0] word_index;

    logic rst4, start4, hold4;
    logic busy4, load_init4, step_en4, final_add4, done4;
    logic [5:0] step_index4;
    logic [1:0] func_sel4;
    logic [3:0] word_index4;

    md5_step_sequencer #(.CYCLES_PER_STEP(1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy),
        .load_init(load_init), .step_en(step_en), .step_index(step_index),
        .func_sel(func_sel), .word_index(word_index), .final_add(final_add), .done(done)
    );

    md5_step_sequencer #(.CYCLES_PER_STEP(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .hold(hold4), .busy(busy4),
        .load_init(load_init4), .step_en(step_en4), .step_index(step_index4),
        .func_sel(func_sel4), .word_index(word_index4), .final_add(final_add4), .done(done4)
    );

    typedef struct {
        int step;
        int func;
        int word;
    } vec_t;
    vec_t tbl[12];

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int obs_word[64];
    int obs_func[64];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // advance one clock, apply this cycle's inputs, let outputs settle
    task automatic cyc_go(input logic s, input logic h);
        @(posedge clk);
        #1;
        start = s;
        hold = h;
        #1;
        cyc++;
    endtask

    task automatic wait_step(input int idx, input int bound, output int at);
        at = -1;
        for (int k = 0; k < bound; k++) begin
            cyc_go(1'b0, 1'b0);
            if (step_en && step_index == 6'(idx)) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_done(input int bound, output int at);
        at = -1;
        for (int k = 0; k < bound; k++) begin
            cyc_go(1'b0, 1'b0);
            if (done) begin
                at = cyc;
                break;
            end
        end
    endtask

    function automatic int ref_word(input int s);
        case (s / 16)
            0: return s % 16;
            1: return (5 * s + 1) % 16;
            2: return (3 * s + 5) % 16;
            default: return (7 * s) % 16;
        endcase
    endfunction

    initial begin
        int t, at, n_done, n_busy, n_se, fa_at, dn_at;
        tbl[0]  = '{16, 1, 1};
        tbl[1]  = '{17, 1, 6};
        tbl[2]  = '{31, 1, 12};
        tbl[3]  = '{32, 2, 5};
        tbl[4]  = '{33, 2, 8};
        tbl[5]  = '{47, 2, 2};
        tbl[6]  = '{48, 3, 0};
        tbl[7]  = '{49, 3, 7};
        tbl[8]  = '{63, 3, 9};
        tbl[9]  = '{0, 0, 0};
        tbl[10] = '{5, 0, 5};
        tbl[11] = '{15, 0, 15};

        rst = 1'b1; start = 1'b0; hold = 1'b0;
        rst4 = 1'b1; start4 = 1'b0; hold4 = 1'b0;
        cyc_go(1'b0, 1'b0);
        cyc_go(1'b0, 1'b0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {load_init, step_en, final_add, done}, 0);
        chk("rst_step", step_index, 0);
        chk("rst_word", word_index, 0);
        chk("rst_func", func_sel, 0);
        chk("rst4_busy", busy4, 0);
        chk("rst4_strobes", {load_init4, step_en4, final_add4, done4}, 0);
        rst = 1'b0;
        rst4 = 1'b0;
        cyc_go(1'b0, 1'b0);
        chk("idle_busy", busy, 0);

        // 1+2: full run, then table of word/func values
        cyc_go(1'b1, 1'b0);
        chk("t1_idle_at_T", busy, 0);
        cyc_go(1'b0, 1'b0);
        chk("t1_load_init", load_init, 1);
        chk("t1_init_busy", busy, 1);
        chk("t1_init_step_en", step_en, 0);
        for (int k = 0; k < 64; k++) begin
            cyc_go(1'b0, 1'b0);
            chk("t1_step_en", step_en, 1);
            chk("t1_step_index", step_index, k);
            chk("t1_word", word_index, ref_word(k));
            obs_word[k] = word_index;
            obs_func[k] = func_sel;
        end
        cyc_go(1'b0, 1'b0);
        chk("t1_final_add", final_add, 1);
        chk("t1_final_step_en", step_en, 0);
        cyc_go(1'b0, 1'b0);
        chk("t1_done", done, 1);
        chk("t1_done_busy", busy, 1);
        cyc_go(1'b0, 1'b0);
        chk("t1_busy_low", busy, 0);
        chk("t1_idle_strobes", {load_init, step_en, final_add, done}, 0);
        chk("t1_idle_step", step_index, 0);
        for (int v = 0; v < 12; v++) begin
            chk($sformatf("t2_func_step%0d", tbl[v].step), obs_func[tbl[v].step], tbl[v].func);
            chk($sformatf("t2_word_step%0d", tbl[v].step), obs_word[tbl[v].step], tbl[v].word);
        end

        // 3: hold for 3 cycles at step 10
        cyc_go(1'b1, 1'b0);
        t = cyc;
        wait_step(9, 100, at);
        chk("t3_step9_at", at - t, 11);
        for (int k = 0; k < 3; k++) begin
            cyc_go(1'b0, 1'b1);
            chk("t3_hold_step", step_index, 10);
            chk("t3_hold_step_en", step_en, 0);
            chk("t3_hold_busy", busy, 1);
        end
        cyc_go(1'b0, 1'b0);
        chk("t3_resume_step_en", step_en, 1);
        chk("t3_resume_step", step_index, 10);
        wait_done(200, at);
        chk("t3_done_at", at - t, 70);
        cyc_go(1'b0, 1'b0);

        // 4: start ignored in RUN and DONE; held start gives back-to-back runs
        cyc_go(1'b1, 1'b0);
        t = cyc;
        wait_step(5, 100, at);
        chk("t4_step5_at", at - t, 7);
        cyc_go(1'b1, 1'b0);
        cyc_go(1'b0, 1'b0);
        chk("t4_run_load_init", load_init, 0);
        chk("t4_run_step", step_index, 7);
        chk("t4_run_step_en", step_en, 1);
        wait_done(200, at);
        chk("t4_done_at", at - t, 67);
        start = 1'b1;
        cyc_go(1'b1, 1'b0);
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_load_init", load_init, 0);
        cyc_go(1'b1, 1'b0);
        chk("t4_second_load_init", load_init, 1);
        chk("t4_second_at", cyc - t, 69);

        // 5: reset mid-run at step 40
        wait_step(39, 100, at);
        cyc_go(1'b0, 1'b0);
        chk("t5_step40", step_index, 40);
        rst = 1'b1;
        cyc_go(1'b0, 1'b0);
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_step", step_index, 0);
        chk("t5_strobes", {load_init, step_en, final_add, done}, 0);
        chk("t5_word", word_index, 0);
        n_done = 0;
        n_busy = 0;
        for (int k = 0; k < 80; k++) begin
            cyc_go(1'b0, 1'b0);
            n_done += int'(done);
            n_busy += int'(busy);
        end
        chk("t5_no_done", n_done, 0);
        chk("t5_stays_idle", n_busy, 0);

        // 6: four cycles per step
        cyc_go(1'b0, 1'b0);
        start4 = 1'b1;
        t = cyc;
        cyc_go(1'b0, 1'b0);
        start4 = 1'b0;
        chk("t6_load_init", load_init4, 1);
        n_se = 0;
        fa_at = -1;
        dn_at = -1;
        for (int k = 0; k < 300 && dn_at < 0; k++) begin
            cyc_go(1'b0, 1'b0);
            if (step_en4) begin
                chk("t6_step_index", step_index4, n_se);
                chk("t6_step_en_at", cyc - t, 1 + 4 * (n_se + 1));
                n_se++;
            end
            if (final_add4) fa_at = cyc - t;
            if (done4) dn_at = cyc - t;
        end
        chk("t6_step_count", n_se, 64);
        chk("t6_final_add_at", fa_at, 258);
        chk("t6_done_at", dn_at, 259);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
